// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Stimulus stage sitting directly upstream of a JK flip-flop. Timed JK commands
// ({j,k} plus a hold length) are buffered in a small FIFO and played out
// back-to-back on the registered j/k outputs. A cycle-accurate model of the
// flip-flop's q (exp_q) is kept alongside and compared with the q that comes
// back from the real flip-flop; mismatches raise a sticky flag and are counted.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low; clears all state immediately
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept (level != DEPTH), no path from cmd_valid
//   cmd_jk     in   {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len    in   command drives for cmd_len+1 cycles
//   chk_en     in   enables q checking
//   q_in       in   q returned from the downstream flip-flop
//   j, k       out  registered drive to the flip-flop
//   busy       out  FSM in DRIVE or FIFO not empty
//   exp_q      out  modelled flip-flop state
//   err        out  sticky mismatch flag (cleared only by reset)
//   err_cnt    out  mismatch count, saturating at 255
//   level      out  FIFO occupancy
//   dbg_state  out  current FSM state (0 = IDLE, 1 = DRIVE)
//
// Handshake: a command is transferred on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on registered occupancy, so a
// full FIFO refuses a command even if an entry is popped on the same edge.
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_jk,
  input  logic [3:0]    cmd_len,
  input  logic          chk_en,
  input  logic          q_in,
  output logic          j,
  output logic          k,
  output logic          busy,
  output logic          exp_q,
  output logic          err,
  output logic [7:0]    err_cnt,
  output logic [AW:0]   level,
  output logic          dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [1:0]    r_mem_jk  [DEPTH];
  logic [3:0]    r_mem_len [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Sequencer and checker state
  state_t        r_state;
  logic [3:0]    r_count;
  logic          r_j;
  logic          r_k;
  logic          r_exp_q;
  logic          r_err;
  logic [7:0]    r_err_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head_jk;
  logic [3:0]    w_head_len;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == FULL_LEVEL);
  assign w_push     = cmd_valid && !w_full;
  // The FSM takes the head whenever it is idle, or when the current command
  // has finished its last cycle; this gives back-to-back playout.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_count == 4'd0));
  assign w_head_jk  = r_mem_jk[r_rd_ptr];
  assign w_head_len = r_mem_len[r_rd_ptr];

  // Storage carries no reset: contents are only ever read below r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_jk[r_wr_ptr]  <= cmd_jk;
      r_mem_len[r_wr_ptr] <= cmd_len;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Playout FSM. r_count holds the remaining extra cycles of the current
  // command, so a command of length L occupies L+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_j, r_k} <= w_head_jk;
            r_count    <= w_head_len;
            r_state    <= S_DRIVE;
          end else begin
            {r_j, r_k} <= 2'b00;
          end
        end
        S_DRIVE: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else if (!w_empty) begin
            {r_j, r_k} <= w_head_jk;
            r_count    <= w_head_len;
          end else begin
            {r_j, r_k} <= 2'b00;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          {r_j, r_k} <= 2'b00;
          r_count    <= 4'd0;
        end
      endcase
    end
  end

  // Flip-flop model: advances from the registered j/k on the same edge the
  // real flip-flop captures them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_q <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b10:   r_exp_q <= 1'b1;
        2'b01:   r_exp_q <= 1'b0;
        2'b11:   r_exp_q <= ~r_exp_q;
        default: r_exp_q <= r_exp_q;
      endcase
    end
  end

  // Checker compares pre-edge q_in with pre-edge exp_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (chk_en && (q_in != r_exp_q)) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign cmd_ready = !w_full;
  assign j         = r_j;
  assign k         = r_k;
  assign busy      = (r_state == S_DRIVE) || !w_empty;
  assign exp_q     = r_exp_q;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign level     = r_level;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_sequencer
//
// Reference model: the FIFO is a queue of commands; the playout is a queue of
// per-cycle {j,k} values (a popped command expands into len+1 copies). The
// front of the playout queue is what j/k show; an empty playout queue means
// idle (j=k=0). The flip-flop model and checker follow the q update rules.
// -----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_jk;
  logic [3:0]    cmd_len;
  logic          chk_en;
  logic          q_in;
  logic          j;
  logic          k;
  logic          busy;
  logic          exp_q;
  logic          err;
  logic [7:0]    err_cnt;
  logic [AW:0]   level;
  logic          dbg_state;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_jk(cmd_jk), .cmd_len(cmd_len), .chk_en(chk_en), .q_in(q_in),
    .j(j), .k(k), .busy(busy), .exp_q(exp_q), .err(err), .err_cnt(err_cnt),
    .level(level), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  m_fifo[$];     // {jk, len}
  logic [1:0]  exp_q_jk[$];   // per-cycle j/k playout
  logic        m_exp;
  logic        m_err;
  int          m_err_cnt;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [1:0] m_jk();
    return (exp_q_jk.size() != 0) ? exp_q_jk[0] : 2'b00;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    exp_q_jk.delete();
    m_exp     = 1'b0;
    m_err     = 1'b0;
    m_err_cnt = 0;
  endtask

  // Called right after a rising edge; inputs and model still hold pre-edge values.
  task automatic model_edge();
    logic [1:0] jk_now;
    logic       push;
    logic [5:0] c;
    jk_now = m_jk();
    push   = cmd_valid && (m_fifo.size() < DEPTH);
    if (chk_en && (q_in != m_exp)) begin
      m_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    case (jk_now)
      2'b10:   m_exp = 1'b1;
      2'b01:   m_exp = 1'b0;
      2'b11:   m_exp = ~m_exp;
      default: m_exp = m_exp;
    endcase
    if (exp_q_jk.size() != 0) void'(exp_q_jk.pop_front());
    if (exp_q_jk.size() == 0 && m_fifo.size() != 0) begin
      c = m_fifo.pop_front();
      for (int i = 0; i <= int'(c[3:0]); i++) exp_q_jk.push_back(c[5:4]);
    end
    if (push) m_fifo.push_back({cmd_jk, cmd_len});
  endtask

  task automatic compare_all();
    logic [1:0] mjk;
    mjk = m_jk();
    check_eq("j", j, mjk[1]);
    check_eq("k", k, mjk[0]);
    check_eq("exp_q", exp_q, m_exp);
    check_eq("err", err, m_err);
    check_eq("err_cnt", err_cnt, m_err_cnt);
    check_eq("level", level, m_fifo.size());
    check_eq("cmd_ready", cmd_ready, (m_fifo.size() < DEPTH) ? 1 : 0);
    check_eq("busy", busy, (exp_q_jk.size() != 0 || m_fifo.size() != 0) ? 1 : 0);
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs at the falling edge, take one rising edge, compare at the next
  // falling edge. q_in follows the model's q, optionally inverted.
  task automatic cycle(input logic v, input logic [1:0] jk, input logic [3:0] len,
                       input logic chk, input logic qerr);
    cmd_valid = v;
    cmd_jk    = jk;
    cmd_len   = len;
    chk_en    = chk;
    q_in      = m_exp ^ qerr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic chk);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 4'd0, chk, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_jk = 2'b00; cmd_len = 4'd0;
    chk_en = 1'b0; q_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Single set command, len 2
    cycle(1'b1, 2'b10, 4'd2, 1'b0, 1'b0);
    idle(6, 1'b0);
    check_eq("single_exp_q", exp_q, 1);

    // Fill and backpressure: alternating set/reset so each start is visible
    for (int i = 0; i < 6; i++)
      cycle(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 4'd15, 1'b0, 1'b0);
    check_eq("fill_level", level, 4);
    idle(6 * 16 + 4, 1'b0);

    // Clear q, then toggle len 3 with matching q_in and checking enabled
    cycle(1'b1, 2'b01, 4'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, 2'b11, 4'd3, 1'b1, 1'b0);
    idle(7, 1'b1);
    check_eq("toggle_err", err, 0);

    // Mismatch: set q, then q_in=0 against exp_q=1
    cycle(1'b1, 2'b10, 4'd15, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b1);
    check_eq("mismatch_cnt3", err_cnt, 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b1);
    check_eq("mismatch_hold3", err_cnt, 3);
    for (int i = 0; i < 300; i++) cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b1);
    check_eq("mismatch_sat", err_cnt, 255);

    // Reset mid-DRIVE with two queued commands
    cycle(1'b1, 2'b10, 4'd10, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 4'd10, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 4'd10, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    check_eq("pre_reset_level", level, 2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("async_j", j, 0);
    check_eq("async_k", k, 0);
    check_eq("async_level", level, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_ready", cmd_ready, 1);
    check_eq("async_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    compare_all();
    idle(8, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    idle(40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its j/k inputs. It buffers timed JK commands (hold/reset/set/toggle plus a hold length) in a small FIFO and plays them out back-to-back. It also keeps a cycle-accurate model of the flip-flop's expected q and flags any mismatch against the q it receives back.

## Interface
- DEPTH, 4, FIFO depth in entries; power of 2, at least 2
- AW, 2, log2(DEPTH)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals (level != DEPTH)
- cmd_jk  in  2  {j,k} to drive: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_len  in  4  hold length; command drives for cmd_len+1 cycles
- chk_en  in  1  enables q checking
- q_in  in  1  q returned from the downstream JK flip-flop
- j, k  out  1 each  registered drive to the flip-flop
- busy  out  1  (state == DRIVE) || (level != 0)
- exp_q  out  1  modelled flip-flop state
- err  out  1  sticky mismatch flag
- err_cnt  out  8  mismatch count, saturates at 255
- level  out  AW+1  FIFO occupancy

## Operation
- Reset values while reset=0: j=k=0, exp_q=0, err=0, err_cnt=0, level=0, FSM=IDLE, count=0, pointers=0, cmd_ready=1, busy=0.
- FIFO:
  - A push occurs on an edge with cmd_valid && cmd_ready.
  - A pop is issued by the FSM.
  - When full, cmd_ready=0 even if a pop happens in the same cycle; there is no bypass.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - j=k=0.
    - If level != 0: pop the head, load j/k from its cmd_jk and count from its cmd_len, then go to DRIVE.
  - DRIVE:
    - j/k are held.
    - If count != 0: decrement count.
    - If count == 0 and level != 0: pop the next entry and load it with no gap cycle. Stay in DRIVE.
    - If count == 0 and level == 0: set j=k=0 and go to IDLE.
- Expected-q model, updated on every edge from the current registered j/k:
  - 10 → 1
  - 01 → 0
  - 11 → ~exp_q
  - 00 → hold
- Checker:
  - On each edge with chk_en=1 and q_in != exp_q (both pre-edge values): set err=1 and increment err_cnt, saturating at 255.
  - err clears only on reset.
- The downstream flip-flop is reset together with this block and resets q to 0.

## Timing
- Command accepted at edge E into an empty FIFO while in IDLE:
  - level=1 after E.
  - Popped at E+1; j/k are valid after E+1.
- A command with cmd_len=L holds j/k for exactly L+1 clock periods.
  - The next command's j/k appear on the following edge; there is no idle cycle between queued commands.
- exp_q reflects a new j/k one edge after j/k change, which is the same edge the flip-flop captures them.
- No combinational path from cmd_valid to cmd_ready.
- reset asserted mid-DRIVE: outputs go to reset values without waiting for clk, and queued commands are discarded.
- reset deassertion is synchronised by the system; the first active edge after release behaves as IDLE with an empty FIFO.

## Test plan
- Reset:
  - Hold reset=0 for 2 cycles → j=k=0, exp_q=0, err=0, err_cnt=0, level=0, cmd_ready=1, busy=0.
- Single set command:
  - Push jk=10, len=2 at edge E → j=1,k=0 after E+1 through E+4 (3 cycles), then j=k=0.
  - exp_q=1 after E+2; busy falls after E+4.
- Fill and backpressure:
  - Push 6 consecutive commands with len=15 → 5 accepted (one popped), 6th sees cmd_ready=0.
  - level=4; each later command starts exactly 16 cycles after the previous one.
- Toggle:
  - From exp_q=0, push jk=11 len=3 → exp_q sequence 1,0,1,0 on successive edges.
  - With q_in matching and chk_en=1, err stays 0.
- Mismatch:
  - chk_en=1, hold q_in=0 while exp_q=1 for 3 edges → err=1, err_cnt=3.
  - chk_en=0 for 3 more edges → err_cnt stays 3.
  - Force 300 mismatches → err_cnt=255.
- Reset mid-operation:
  - Assert reset during DRIVE with level=2 → j=k=0, level=0 and busy=0 immediately (before the next clk edge).
  - After release, no stale command is issued.
